// File: rtl/square_rem_int.sv
// Pipelined integer squarer with remainder add-back: rad = root*root + rem (shift-add per root bit).
// Optional build macro SQUARE_REM_CHECK_EN adds a rem > 2*root range flag carried alongside valid.
module square_rem_int #(
    parameter int DATAWIDTH           = 8,
    parameter int NUM_PIPELINE_STAGES = 1,
    parameter int INSTANCE_ID         = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [DATAWIDTH/2-1:0] root,
    input  logic [DATAWIDTH/2:0]   rem,
    output logic                   o_valid,
    output logic [DATAWIDTH-1:0]   rad,
    output logic                   o_err
);
    localparam int H   = DATAWIDTH / 2;
    localparam int AW  = DATAWIDTH + 1;
    localparam int NPS = NUM_PIPELINE_STAGES;
    localparam int unused_instance_id = INSTANCE_ID;

    // slot 0: input register
    logic         s0_vld;
    logic [H-1:0] s0_root;
    logic [H:0]   s0_rem;

    generate
        if (NPS > 0) begin : g_s0_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s0_vld  <= 1'b0;
                    s0_root <= '0;
                    s0_rem  <= '0;
                end else begin
                    s0_vld  <= i_valid;
                    s0_root <= root;
                    s0_rem  <= rem;
                end
            end
        end else begin : g_s0_wire
            assign s0_vld  = i_valid;
            assign s0_root = root;
            assign s0_rem  = rem;
        end
    endgenerate

    // Element k feeds iteration k; element H feeds the output slot.
    logic          vld_pipe [H+1];
    logic [AW-1:0] acc_pipe [H+1];
    logic [H-1:0]  rt_pipe  [H];

    // Invalid beats enter the iterations as zero so rad stays 0 whenever o_valid is low.
    assign vld_pipe[0] = s0_vld;
    assign acc_pipe[0] = s0_vld ? AW'(s0_rem) : '0;
    assign rt_pipe[0]  = s0_vld ? s0_root : '0;

`ifdef SQUARE_REM_CHECK_EN
    logic rerr_pipe [H+1];
    assign rerr_pipe[0] = s0_vld && (s0_rem > {s0_root, 1'b0});
`endif

    // slots 1..H: add rt << k when root bit k is set
    generate
        for (genvar k = 0; k < H; k++) begin : g_iter
            logic [AW-1:0] acc_nxt;
            assign acc_nxt = acc_pipe[k] + (rt_pipe[k][k] ? (AW'(rt_pipe[k]) << k) : AW'(0));

            if (k + 1 < NPS) begin : g_reg
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_pipe[k+1] <= 1'b0;
                        acc_pipe[k+1] <= '0;
                    end else begin
                        vld_pipe[k+1] <= vld_pipe[k];
                        acc_pipe[k+1] <= acc_nxt;
                    end
                end
`ifdef SQUARE_REM_CHECK_EN
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) rerr_pipe[k+1] <= 1'b0;
                    else     rerr_pipe[k+1] <= rerr_pipe[k];
                end
`endif
                if (k + 1 < H) begin : g_rt
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) rt_pipe[k+1] <= '0;
                        else     rt_pipe[k+1] <= rt_pipe[k];
                    end
                end
            end else begin : g_wire
                assign vld_pipe[k+1] = vld_pipe[k];
                assign acc_pipe[k+1] = acc_nxt;
`ifdef SQUARE_REM_CHECK_EN
                assign rerr_pipe[k+1] = rerr_pipe[k];
`endif
                if (k + 1 < H) begin : g_rt
                    assign rt_pipe[k+1] = rt_pipe[k];
                end
            end
        end
    endgenerate

    // slot H+1: output register
    logic [DATAWIDTH-1:0] rad_nxt;
    logic                 err_nxt;
    assign rad_nxt = acc_pipe[H][DATAWIDTH-1:0];
`ifdef SQUARE_REM_CHECK_EN
    assign err_nxt = acc_pipe[H][DATAWIDTH] | rerr_pipe[H];
`else
    assign err_nxt = acc_pipe[H][DATAWIDTH];
`endif

    generate
        if (H + 1 < NPS) begin : g_out_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    o_valid <= 1'b0;
                    rad     <= '0;
                    o_err   <= 1'b0;
                end else begin
                    o_valid <= vld_pipe[H];
                    rad     <= rad_nxt;
                    o_err   <= err_nxt;
                end
            end
        end else begin : g_out_wire
            assign o_valid = vld_pipe[H];
            assign rad     = rad_nxt;
            assign o_err   = err_nxt;
        end
    endgenerate

endmodule

// File: tb/tb_square_rem_int.sv
// Scoreboard bench for square_rem_int: four instances (6, 0, 1, 3 stages) share one stimulus stream.
module tb_square_rem_int;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_valid;
    logic [3:0] root;
    logic [4:0] rem;
    logic       ov [4];
    logic [7:0] rd [4];
    logic       oe [4];

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rad;
        logic       err;
        int         due;
    } exp_t;

    exp_t sbq [4][$];
    exp_t e_mon;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] sq [16] = '{0, 1, 4, 9, 16, 25, 36, 49, 64, 81, 100, 121, 144, 169, 196, 225};

`ifdef SQUARE_REM_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    square_rem_int #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(6), .INSTANCE_ID(0)) u_dut6 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .root(root), .rem(rem),
        .o_valid(ov[0]), .rad(rd[0]), .o_err(oe[0]));
    square_rem_int #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(0), .INSTANCE_ID(1)) u_dut0 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .root(root), .rem(rem),
        .o_valid(ov[1]), .rad(rd[1]), .o_err(oe[1]));
    square_rem_int #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(1), .INSTANCE_ID(2)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .root(root), .rem(rem),
        .o_valid(ov[2]), .rad(rd[2]), .o_err(oe[2]));
    square_rem_int #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(3), .INSTANCE_ID(3)) u_dut3 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .root(root), .rem(rem),
        .o_valid(ov[3]), .rad(rd[3]), .o_err(oe[3]));

    function automatic int lat(input int d);
        case (d)
            0: return 6;
            1: return 0;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pop on every o_valid; idle beats must read as zero
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ov[d]) begin
                if (sbq[d].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out dut%0d cyc=%0d got rad=%0d err=%0d, required no output",
                             d, cyc, rd[d], oe[d]);
                end else begin
                    e_mon = sbq[d].pop_front();
                    if (rd[d] !== e_mon.rad || oe[d] !== e_mon.err || cyc != e_mon.due) begin
                        errors++;
                        $display("FAIL result dut%0d got rad=%0d err=%0d cyc=%0d, required rad=%0d err=%0d cyc=%0d",
                                 d, rd[d], oe[d], cyc, e_mon.rad, e_mon.err, e_mon.due);
                    end
                end
            end else if (rd[d] !== 8'd0 || oe[d] !== 1'b0) begin
                errors++;
                $display("FAIL idle_zero dut%0d cyc=%0d got rad=%0d err=%0d, required rad=0 err=0",
                         d, cyc, rd[d], oe[d]);
            end
        end
    end

    task automatic issue(input logic [3:0] r, input logic [4:0] m, input logic [7:0] er, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        i_valid = 1'b1;
        root    = r;
        rem     = m;
        for (int d = 0; d < 4; d++) begin
            e.rad = er;
            e.err = ee;
            e.due = cyc + lat(d);
            sbq[d].push_back(e);
        end
    endtask

    // invalid beat carrying garbage data, which must not leak to rad
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
            root    = 4'($urandom_range(0, 15));
            rem     = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic check_zero(input string name);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || rd[d] !== 8'd0 || oe[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d got valid=%0d rad=%0d err=%0d, required all 0",
                         name, d, ov[d], rd[d], oe[d]);
            end
        end
    endtask

    initial begin
        i_valid = 1'b0;
        root    = '0;
        rem     = '0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;

        // boundary: max root with max legal rem, then zero operands
        issue(4'd15, 5'd30, 8'd255, 1'b0);
        idle(8);
        issue(4'd0, 5'd0, 8'd0, 1'b0);
        idle(8);

        // overflow wraps, then an out-of-range rem that does not overflow
        issue(4'd15, 5'd31, 8'd0, 1'b1);
        issue(4'd3, 5'd7, 8'd16, CHK);
        idle(8);

        // streaming squares with a two-beat gap after root=7
        for (int r = 0; r < 8; r++) issue(4'(r), 5'd0, sq[r], 1'b0);
        idle(2);
        for (int r = 8; r < 16; r++) issue(4'(r), 5'd0, sq[r], 1'b0);
        idle(8);

        issue(4'd10, 5'd5, 8'd105, 1'b0);
        idle(8);

        // asynchronous reset with samples in flight
        issue(4'd1, 5'd2, 8'd3, 1'b0);
        issue(4'd2, 5'd1, 8'd5, 1'b0);
        issue(4'd5, 5'd5, 8'd30, 1'b0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        root    = '0;
        rem     = '0;
        #2;
        rst = 1'b1;
        for (int d = 0; d < 4; d++) sbq[d].delete();
        #1;
        check_zero("reset_async");
        rst = 1'b0;
        idle(8);
        issue(4'd9, 5'd4, 8'd85, 1'b0);
        idle(8);

        // round trip over every 8-bit radicand via floor-sqrt decomposition
        for (int x = 0; x < 256; x++) begin
            int r;
            r = 0;
            while ((r + 1) * (r + 1) <= x) r++;
            issue(4'(r), 5'(x - r * r), 8'(x), 1'b0);
        end
        idle(10);

        for (int d = 0; d < 4; d++) begin
            checks++;
            if (sbq[d].size() != 0) begin
                errors++;
                $display("FAIL missing_out dut%0d got %0d results outstanding, required 0", d, sbq[d].size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
